// File: rtl/countdown_timer.sv
// Purpose : 4-bit loadable down-counter with prescaled tick, run/expire FSM, optional auto-reload.
// Latency : Q/BO/DONE/isHalf all come straight from registers; a tick or load shows one edge later.
// Backpress: none; ENP/ENT freeze the prescaler and count in place, ENT also gates the borrow out.
//
// Ports:
//   CLK50M  - sole clock, rising edge
//   CLRb    - asynchronous active-low clear
//   LDb     - synchronous active-low load of D into Q and the reload register
//   D[3:0]  - load value
//   ENP,ENT - count enables (both needed); ENT doubles as cascade gate
//   START   - run request level, its rising edge is acted on
//   Q[3:0]  - current count
//   BO      - registered one-cycle borrow pulse on expiry
//   DONE    - high while expired
//   isHalf  - high during the second half of each tick period while running
module countdown_timer #(
  parameter int TICK_DIV    = 25_000_000,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       CLK50M,
  input  logic       CLRb,
  input  logic       LDb,
  input  logic [3:0] D,
  input  logic       ENP,
  input  logic       ENT,
  input  logic       START,
  output logic [3:0] Q,
  output logic       BO,
  output logic       DONE,
  output logic       isHalf
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    q_q, q_d;
  logic [3:0]    rld_q, rld_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          bo_q, bo_d;
  logic          start_q;
  // Stays low for the first clock after reset so a START level held
  // through reset release is not mistaken for a rising edge.
  logic          arm_q;

  logic en;
  logic start_edge;
  logic tick;

  assign en         = ENP & ENT;
  assign start_edge = arm_q & START & ~start_q;
  assign tick       = (state_q == S_RUN) & en & (ps_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    ps_d    = '0;
    bo_d    = 1'b0;

    // Prescaler only moves while running; it sits at zero elsewhere, so
    // every entry to RUN starts a full tick period.
    if (state_q == S_RUN) begin
      if (en) begin
        ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
      end else begin
        ps_d = ps_q;
      end
    end

    if (!LDb) begin
      // Load wins over tick and START; prescaler phase is kept in RUN.
      q_d   = D;
      rld_d = D;
      case (state_q)
        S_RUN:     if (D == 4'd0) state_d = S_EXPIRED;
        S_EXPIRED: state_d = S_IDLE;
        default:   state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d = (q_q != 4'd0) ? S_RUN : S_EXPIRED;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (q_q == 4'd1) begin
              bo_d = 1'b1;
              if (AUTO_RELOAD) begin
                q_d = rld_q;
                if (rld_q == 4'd0) state_d = S_EXPIRED;
              end else begin
                q_d     = 4'd0;
                state_d = S_EXPIRED;
              end
            end else if (q_q != 4'd0) begin
              q_d = q_q - 4'd1;
            end
          end
        end
        S_EXPIRED: begin
          if (start_edge) begin
            q_d = rld_q;
            if (rld_q != 4'd0) state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50M or negedge CLRb) begin
    if (!CLRb) begin
      state_q <= S_IDLE;
      q_q     <= 4'd0;
      rld_q   <= 4'd0;
      ps_q    <= '0;
      bo_q    <= 1'b0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      ps_q    <= ps_d;
      bo_q    <= bo_d;
      start_q <= START;
      arm_q   <= 1'b1;
    end
  end

  assign Q      = q_q;
  assign BO     = bo_q;
  assign DONE   = (state_q == S_EXPIRED);
  assign isHalf = (state_q == S_RUN) && (ps_q >= PS_HALF);

endmodule

// File: tb/tb_countdown_timer.sv
// Purpose : self-checking bench for countdown_timer, one instance per AUTO_RELOAD setting.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpress: n/a.
module tb_countdown_timer;

  localparam int TD     = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic       clk = 1'b0;
  logic       clrb, ld_b, enp, ent, start;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       bo0, bo1, done0, done1, half0, half1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: count value, reload value, mode, number of enabled
  // cycles elapsed in the current tick period, pending borrow.
  int m_q[2], m_rld[2], m_mode[2], m_ph[2], m_bo[2], m_prev[2], m_arm[2];

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(TD), .AUTO_RELOAD(1'b0)) u_dut0 (
    .CLK50M(clk), .CLRb(clrb), .LDb(ld_b), .D(d), .ENP(enp), .ENT(ent),
    .START(start), .Q(q0), .BO(bo0), .DONE(done0), .isHalf(half0)
  );

  countdown_timer #(.TICK_DIV(TD), .AUTO_RELOAD(1'b1)) u_dut1 (
    .CLK50M(clk), .CLRb(clrb), .LDb(ld_b), .D(d), .ENP(enp), .ENT(ent),
    .START(start), .Q(q1), .BO(bo1), .DONE(done1), .isHalf(half1)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_rld[k] = 0; m_mode[k] = M_IDLE; m_ph[k] = 0;
      m_bo[k] = 0; m_prev[k] = 0; m_arm[k] = 0;
    end
  endtask

  task automatic model_clock(input int k, input int ar);
    int en, sedge, dv;
    en    = (enp && ent) ? 1 : 0;
    sedge = (m_arm[k] != 0 && start && m_prev[k] == 0) ? 1 : 0;
    dv    = int'(d);
    m_bo[k] = 0;
    if (!ld_b) begin
      m_q[k] = dv; m_rld[k] = dv;
      if (m_mode[k] == M_RUN) begin
        if (en != 0) m_ph[k] = (m_ph[k] + 1) % TD;
        if (dv == 0) m_mode[k] = M_EXP;
      end else if (m_mode[k] == M_EXP) begin
        m_mode[k] = M_IDLE;
      end
    end else if (m_mode[k] == M_IDLE) begin
      if (sedge != 0) begin
        m_ph[k]   = 0;
        m_mode[k] = (m_q[k] != 0) ? M_RUN : M_EXP;
      end
    end else if (m_mode[k] == M_RUN) begin
      if (en != 0) begin
        if (m_ph[k] == TD - 1) begin
          m_ph[k] = 0;
          if (m_q[k] == 1) begin
            m_bo[k] = 1;
            m_q[k]  = (ar != 0) ? m_rld[k] : 0;
            if (m_q[k] == 0) m_mode[k] = M_EXP;
          end else if (m_q[k] > 0) begin
            m_q[k] = m_q[k] - 1;
          end
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
    end else begin
      if (sedge != 0) begin
        m_q[k] = m_rld[k];
        if (m_rld[k] != 0) begin
          m_ph[k] = 0; m_mode[k] = M_RUN;
        end
      end
    end
    m_prev[k] = start ? 1 : 0;
    m_arm[k]  = 1;
  endtask

  // Advance one clock with the inputs currently driven.
  task automatic step();
    if (!clrb) model_reset();
    else begin
      model_clock(0, 0);
      model_clock(1, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clrb = 1'b0; ld_b = 1'b1; start = 1'b0; enp = 1'b1; ent = 1'b1; d = 4'd0;
    #1;
    step(); step();
    clrb = 1'b1;
  endtask

  task automatic load_and_start(input logic [3:0] v);
    ld_b = 1'b0; d = v; step();
    ld_b = 1'b1; start = 1'b1; step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if ({q0, bo0, done0, half0} !== 7'd0) begin
      n_bad++; $display("FAIL reset_dut0: got %b want 0000000", {q0, bo0, done0, half0});
    end
    n_cmp++; if ({q1, bo1, done1, half1} !== 7'd0) begin
      n_bad++; $display("FAIL reset_dut1: got %b want 0000000", {q1, bo1, done1, half1});
    end
  endtask

  task automatic test_load_start();
    apply_reset();
    ld_b = 1'b0; d = 4'd3; step();
    ld_b = 1'b1;
    n_cmp++; if (q0 !== 4'd3 || done0 !== 1'b0) begin
      n_bad++; $display("FAIL load_q: got q=%0d done=%b want q=3 done=0", q0, done0);
    end
    start = 1'b1; step(); start = 1'b0;  // entry to RUN
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 2 || i == 3) begin
        n_cmp++; if (half0 !== 1'b1) begin
          n_bad++; $display("FAIL half_hi_%0d: got %b want 1", i, half0);
        end
      end
      if (i == 4 || i == 5) begin
        n_cmp++; if (half0 !== 1'b0) begin
          n_bad++; $display("FAIL half_lo_%0d: got %b want 0", i, half0);
        end
      end
      if (i == 4 || i == 8 || i == 12) begin
        n_cmp++; if (q0 !== 4'(3 - i / 4)) begin
          n_bad++; $display("FAIL count_%0d: got %0d want %0d", i, q0, 3 - i / 4);
        end
      end
      n_cmp++; if (bo0 !== (i == 12)) begin
        n_bad++; $display("FAIL bo_at_%0d: got %b want %b", i, bo0, i == 12);
      end
    end
    n_cmp++; if (done0 !== 1'b1 || q0 !== 4'd0 || half0 !== 1'b0) begin
      n_bad++; $display("FAIL expired: got done=%b q=%0d half=%b want 1 0 0", done0, q0, half0);
    end
  endtask

  task automatic test_pause();
    int found;
    apply_reset();
    load_and_start(4'd2);
    step(); step();  // prescaler mid-tick
    enp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (q0 !== 4'd2 || half0 !== 1'b1) begin
        n_bad++; $display("FAIL pause_hold_%0d: got q=%0d half=%b want 2 1", i, q0, half0);
      end
    end
    enp = 1'b1;
    found = -1;
    for (int i = 8; i <= 40 && found < 0; i++) begin
      step();
      if (bo0) found = i;
    end
    n_cmp++; if (found != 13) begin
      n_bad++; $display("FAIL pause_expiry: got cycle %0d want 13", found);
    end
  endtask

  task automatic test_autoreload();
    apply_reset();
    load_and_start(4'd2);
    for (int i = 1; i <= 31; i++) begin
      step();
      n_cmp++; if (bo1 !== (i % 8 == 0) || done1 !== 1'b0) begin
        n_bad++; $display("FAIL ar_bo_%0d: got bo=%b done=%b want %b 0", i, bo1, done1, i % 8 == 0);
      end
      if (i == 8) begin
        n_cmp++; if (q1 !== 4'd2 || done0 !== 1'b1) begin
          n_bad++; $display("FAIL ar_reload: got q1=%0d done0=%b want 2 1", q1, done0);
        end
      end
    end
    ent = 1'b0; step();
    n_cmp++; if (bo1 !== 1'b0 || q1 !== 4'd1) begin
      n_bad++; $display("FAIL ent_gate: got bo=%b q=%0d want 0 1", bo1, q1);
    end
    ent = 1'b1; step();
    n_cmp++; if (bo1 !== 1'b1 || q1 !== 4'd2) begin
      n_bad++; $display("FAIL ent_resume: got bo=%b q=%0d want 1 2", bo1, q1);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    load_and_start(4'd1);
    step(); step(); step();  // now on the tick cycle with Q == 1
    ld_b = 1'b0; d = 4'd5; step(); ld_b = 1'b1;
    n_cmp++; if (q0 !== 4'd5 || bo0 !== 1'b0 || done0 !== 1'b0) begin
      n_bad++; $display("FAIL ld_on_tick: got q=%0d bo=%b done=%b want 5 0 0", q0, bo0, done0);
    end
    step(); step(); step(); step();
    n_cmp++; if (q0 !== 4'd4 || bo0 !== 1'b0) begin
      n_bad++; $display("FAIL ld_keeps_run: got q=%0d bo=%b want 4 0", q0, bo0);
    end
    ld_b = 1'b0; d = 4'd0; step(); ld_b = 1'b1;
    n_cmp++; if (done0 !== 1'b1 || q0 !== 4'd0 || bo0 !== 1'b0) begin
      n_bad++; $display("FAIL ld_zero: got done=%b q=%0d bo=%b want 1 0 0", done0, q0, bo0);
    end
    step();
    n_cmp++; if (bo0 !== 1'b0) begin
      n_bad++; $display("FAIL ld_zero_bo: got %b want 0", bo0);
    end
    ld_b = 1'b0; d = 4'd0; step(); ld_b = 1'b1;  // back to IDLE with Q == 0
    n_cmp++; if (done0 !== 1'b0) begin
      n_bad++; $display("FAIL ld_exp_idle: got done=%b want 0", done0);
    end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (done0 !== 1'b1 || bo0 !== 1'b0 || q0 !== 4'd0) begin
      n_bad++; $display("FAIL start_q0: got done=%b bo=%b q=%0d want 1 0 0", done0, bo0, q0);
    end
    step();
    n_cmp++; if (bo0 !== 1'b0) begin
      n_bad++; $display("FAIL start_q0_bo: got %b want 0", bo0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_and_start(4'd3);
    start = 1'b1;
    step(); step(); step(); step();
    n_cmp++; if (q0 !== 4'd2) begin
      n_bad++; $display("FAIL mid_pre: got q=%0d want 2", q0);
    end
    clrb = 1'b0; model_reset(); #1;
    n_cmp++; if ({q0, bo0, done0, half0} !== 7'd0) begin
      n_bad++; $display("FAIL mid_async: got %b want 0000000", {q0, bo0, done0, half0});
    end
    step(); step();
    clrb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if ({q0, bo0, done0, half0} !== 7'd0) begin
        n_bad++; $display("FAIL mid_idle_%0d: got %b want 0000000", i, {q0, bo0, done0, half0});
      end
    end
    start = 1'b0;
    load_and_start(4'd2);
    step(); step(); step(); step();
    n_cmp++; if (q0 !== 4'd1) begin
      n_bad++; $display("FAIL mid_restart: got q=%0d want 1", q0);
    end
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      clrb  = ($urandom_range(0, 299) != 0);
      ld_b  = ($urandom_range(0, 19) != 0);
      d     = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      enp   = ($urandom_range(0, 9) != 0);
      ent   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) start = ~start;
      step();
      for (int k = 0; k < 2; k++) begin
        want = {4'(m_q[k]), m_bo[k] != 0, m_mode[k] == M_EXP,
                m_mode[k] == M_RUN && m_ph[k] >= TD / 2};
        got  = (k == 0) ? {q0, bo0, done0, half0} : {q1, bo1, done1, half1};
        n_cmp++; if (got !== want) begin
          n_bad++; $display("FAIL rand_dut%0d_cyc%0d: got %b want %b", k, i, got, want);
        end
      end
    end
  endtask

  initial begin
    clrb = 1'b0; ld_b = 1'b1; start = 1'b0; enp = 1'b1; ent = 1'b1; d = 4'd0;
    model_reset();
    test_reset();
    test_load_start();
    test_pause();
    test_autoreload();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
